bfp16_dot_seq: RTL

Sequencer that drives the `bfp16_mac` multiply-add unit to compute a BF16 dot product: O = bias + Σ W[k]·I[k], k = 0..len-1. It accepts an operand stream, issues one (W, I, P) triple at a time, and feeds each MAC result back as the next P. It returns the final sum on a valid/ready result port. It sits between the operand buffers and `bfp16_mac`, which is instantiated beside it and not inside it.

---
 rtl/bfp16_pkg.sv | 18 +
 rtl/bfp16_dot_seq.sv | 109 ++++++++++
 2 files changed

// File: rtl/bfp16_pkg.sv
// Shared BF16 types and constants for the dot-product sequencer.
// Provides bf16_t, BF16_ZERO/BF16_ONE and the dot_state_t FSM encoding.
`timescale 1ns/1ps
package bfp16_pkg;

  typedef logic [15:0] bf16_t;

  localparam bf16_t BF16_ZERO = 16'h0000;
  localparam bf16_t BF16_ONE  = 16'h3F80;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } dot_state_t;

endpackage

// File: rtl/bfp16_dot_seq.sv
// BF16 dot-product sequencer: O = bias + sum W[k]*I[k], driving an external MAC.
// Ports: start/len/bias job request, op_* operand stream (valid/ready),
//        mac_w/mac_i/mac_p registered MAC operands, mac_o MAC result,
//        res_* final result (valid/ready), busy = not IDLE.
`timescale 1ns/1ps
module bfp16_dot_seq
  import bfp16_pkg::*;
#(
  parameter int DATA_TYPE = 16,
  parameter int LEN_W     = 8,
  parameter int MAC_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  input  logic [DATA_TYPE-1:0] bias,
  output logic                 busy,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [DATA_TYPE-1:0] op_w,
  input  logic [DATA_TYPE-1:0] op_i,
  output logic [DATA_TYPE-1:0] mac_w,
  output logic [DATA_TYPE-1:0] mac_i,
  output logic [DATA_TYPE-1:0] mac_p,
  input  logic [DATA_TYPE-1:0] mac_o,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DATA_TYPE-1:0] res_data
);

  localparam int WCNT_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

  dot_state_t           state, state_n;
  logic [DATA_TYPE-1:0] acc, acc_n;
  logic [LEN_W-1:0]     cnt, cnt_n;
  logic [WCNT_W-1:0]    wcnt, wcnt_n;
  logic [DATA_TYPE-1:0] mw_n, mi_n, mp_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      wcnt  <= '0;
      mac_w <= '0;
      mac_i <= '0;
      mac_p <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      wcnt  <= wcnt_n;
      mac_w <= mw_n;
      mac_i <= mi_n;
      mac_p <= mp_n;
    end
  end

  always_comb begin
    state_n  = state;
    acc_n    = acc;
    cnt_n    = cnt;
    wcnt_n   = wcnt;
    mw_n     = mac_w;
    mi_n     = mac_i;
    mp_n     = mac_p;
    op_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          acc_n   = bias;
          cnt_n   = len;
          state_n = (len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          mw_n    = op_w;
          mi_n    = op_i;
          mp_n    = acc;
          wcnt_n  = WCNT_W'(MAC_LAT);
          state_n = WAIT;
        end
      end
      WAIT: begin
        // wcnt reaches zero MAC_LAT edges after the load,
        // so mac_o is taken on edge MAC_LAT+1.
        if (wcnt == '0) begin
          acc_n   = mac_o;
          cnt_n   = cnt - 1'b1;
          state_n = (cnt == LEN_W'(1)) ? DONE : ISSUE;
        end else begin
          wcnt_n = wcnt - 1'b1;
        end
      end
      DONE: begin
        if (res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);
  assign res_data  = acc;

endmodule
